// File: rtl/avst_crdt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// avst_crdt_tx_ctrl
// Credit issuer for the AVST credit-control channel. Sits in front of the local
// receive buffer, performs the INIT/INIT_ACK handshake with the peer (the credit
// consumer), advertises INIT_CREDITS after the handshake and then hands back
// every credit the local buffer frees as UPDATE/UPDATE_CNT pulses.
//
// Ports
//   i_clk          clock
//   i_reset        synchronous reset, active-high
//   i_reinit       one-cycle request to restart credit init (e.g. link retrain)
//   i_release      local buffer freed i_release_cnt credits this cycle
//   i_release_cnt  number of credits freed (0 with i_release=1 is a no-op)
//   o_init         credit init request to the peer
//   i_init_ack     peer acknowledges init
//   o_update       credit return strobe
//   o_update_cnt   credits returned with o_update (0 when o_update=0)
//   o_ready        credit channel up (running state)
//   o_err          one-cycle pulse: credit conservation violated
// -----------------------------------------------------------------------------
module avst_crdt_tx_ctrl #(
    parameter int UPDATE_CNT_WIDTH  = 8,
    parameter int RELEASE_CNT_WIDTH = 4,
    parameter int INIT_CREDITS      = 512
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_reinit,
    input  logic                         i_release,
    input  logic [RELEASE_CNT_WIDTH-1:0] i_release_cnt,
    output logic                         o_init,
    input  logic                         i_init_ack,
    output logic                         o_update,
    output logic [UPDATE_CNT_WIDTH-1:0]  o_update_cnt,
    output logic                         o_ready,
    output logic                         o_err
);

    localparam int PW      = $clog2(INIT_CREDITS + 1);
    localparam int MAX_UPD = (2 ** UPDATE_CNT_WIDTH) - 1;
    // Working width for the credit arithmetic: wide enough for the pending
    // count, the per-pulse maximum and a release, plus one carry bit so the
    // overflow comparison against INIT_CREDITS can never wrap.
    localparam int CW_A    = (PW > UPDATE_CNT_WIDTH) ? PW : UPDATE_CNT_WIDTH;
    localparam int CW      = ((CW_A > RELEASE_CNT_WIDTH) ? CW_A : RELEASE_CNT_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [PW-1:0]               r_pending;
    logic [PW-1:0]               w_pending_nxt;

    logic                        w_init_nxt;
    logic                        w_update_nxt;
    logic [UPDATE_CNT_WIDTH-1:0] w_update_cnt_nxt;
    logic                        w_ready_nxt;
    logic                        w_err_nxt;

    logic [CW-1:0]               w_pend_ext;
    logic [CW-1:0]               w_sent;
    logic [CW-1:0]               w_left;
    logic [CW-1:0]               w_rel;
    logic [CW-1:0]               w_sum;
    logic                        w_over;

    // Credit arithmetic: amount sent this cycle, remaining backlog and overflow test
    always_comb begin
        w_pend_ext = CW'(r_pending);
        if (w_pend_ext < CW'(MAX_UPD)) begin
            w_sent = w_pend_ext;
        end else begin
            w_sent = CW'(MAX_UPD);
        end
        w_left = w_pend_ext - w_sent;
        if (i_release) begin
            w_rel = CW'(i_release_cnt);
        end else begin
            w_rel = {CW{1'b0}};
        end
        w_sum  = w_left + w_rel;
        // More credits outstanding locally than the buffer holds: the release is bogus.
        w_over = (w_sum > CW'(INIT_CREDITS));
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a reinit request overrides everything, including INIT_ACK
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_INIT;
            end
            S_INIT: begin
                if (i_init_ack) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_INIT;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_reinit) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Output/pending next values; everything here is registered on the next edge
    always_comb begin
        w_init_nxt       = 1'b0;
        w_update_nxt     = 1'b0;
        w_update_cnt_nxt = {UPDATE_CNT_WIDTH{1'b0}};
        w_ready_nxt      = 1'b0;
        w_err_nxt        = 1'b0;
        w_pending_nxt    = r_pending;
        if (i_reinit) begin
            // Credits in flight are discarded; the peer is re-initialised from scratch.
            w_pending_nxt = {PW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_init_nxt    = 1'b1;
                    w_pending_nxt = {PW{1'b0}};
                end
                S_INIT: begin
                    if (i_init_ack) begin
                        // Whole buffer becomes the backlog; it drains from the next cycle.
                        w_ready_nxt   = 1'b1;
                        w_pending_nxt = PW'(INIT_CREDITS);
                    end else begin
                        // Releases are meaningless before the peer has been told anything.
                        w_init_nxt    = 1'b1;
                        w_pending_nxt = {PW{1'b0}};
                    end
                end
                S_RUN: begin
                    w_ready_nxt      = 1'b1;
                    w_update_nxt     = (w_sent != {CW{1'b0}});
                    w_update_cnt_nxt = UPDATE_CNT_WIDTH'(w_sent);
                    if (w_over) begin
                        w_err_nxt     = 1'b1;
                        w_pending_nxt = PW'(w_left);
                    end else begin
                        w_err_nxt     = 1'b0;
                        w_pending_nxt = PW'(w_sum);
                    end
                end
                default: begin
                    w_pending_nxt = {PW{1'b0}};
                end
            endcase
        end
    end

    // Registered outputs and pending credit counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_init       <= 1'b0;
            o_update     <= 1'b0;
            o_update_cnt <= {UPDATE_CNT_WIDTH{1'b0}};
            o_ready      <= 1'b0;
            o_err        <= 1'b0;
            r_pending    <= {PW{1'b0}};
        end else begin
            o_init       <= w_init_nxt;
            o_update     <= w_update_nxt;
            o_update_cnt <= w_update_cnt_nxt;
            o_ready      <= w_ready_nxt;
            o_err        <= w_err_nxt;
            r_pending    <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_avst_crdt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_avst_crdt_tx_ctrl
// Drives two instances of avst_crdt_tx_ctrl from the same inputs: one with the
// default parameters and a small one (MAX_UPD=3, INIT_CREDITS=10) in which an
// over-release is reachable. Each instance is followed by a cycle-level
// reference model built from the credit rules with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_avst_crdt_tx_ctrl;

    localparam int A_UCW = 8;
    localparam int A_RCW = 4;
    localparam int A_IC  = 512;
    localparam int A_MAX = 255;
    localparam int B_UCW = 2;
    localparam int B_RCW = 4;
    localparam int B_IC  = 10;
    localparam int B_MAX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             reinit;
    logic             rel;
    logic [3:0]       rel_cnt;
    logic             ack;

    logic             a_init, a_upd, a_rdy, a_err;
    logic [A_UCW-1:0] a_cnt;
    logic             b_init, b_upd, b_rdy, b_err;
    logic [B_UCW-1:0] b_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int sum_a    = 0;
    int hold_upd = 0;
    int burst[3];

    typedef struct {
        int phase;   // 0 idle, 1 waiting for ack, 2 running
        int pend;
        int init;
        int upd;
        int cnt;
        int rdy;
        int err;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    avst_crdt_tx_ctrl #(
        .UPDATE_CNT_WIDTH (A_UCW),
        .RELEASE_CNT_WIDTH(A_RCW),
        .INIT_CREDITS     (A_IC)
    ) u_dut_a (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_reinit     (reinit),
        .i_release    (rel),
        .i_release_cnt(rel_cnt),
        .o_init       (a_init),
        .i_init_ack   (ack),
        .o_update     (a_upd),
        .o_update_cnt (a_cnt),
        .o_ready      (a_rdy),
        .o_err        (a_err)
    );

    avst_crdt_tx_ctrl #(
        .UPDATE_CNT_WIDTH (B_UCW),
        .RELEASE_CNT_WIDTH(B_RCW),
        .INIT_CREDITS     (B_IC)
    ) u_dut_b (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_reinit     (reinit),
        .i_release    (rel),
        .i_release_cnt(rel_cnt),
        .o_init       (b_init),
        .i_init_ack   (ack),
        .o_update     (b_upd),
        .o_update_cnt (b_cnt),
        .o_ready      (b_rdy),
        .o_err        (b_err)
    );

    always #5 clk = ~clk;

    // Reference: what the issuer must show after one clock edge given the inputs at that edge
    function automatic mdl_t mdl_step(input mdl_t m, input int ic, input int mx,
                                      input logic rst_v, input logic reinit_v,
                                      input logic rel_v, input int rel_n, input logic ack_v);
        mdl_t n;
        int   sent;
        int   after;
        n = '{default: 0};
        if (rst_v || reinit_v) return n;
        if (m.phase == 0) begin
            n.phase = 1;
            n.init  = 1;
        end else if (m.phase == 1) begin
            if (ack_v) begin
                n.phase = 2;
                n.pend  = ic;
                n.rdy   = 1;
            end else begin
                n.phase = 1;
                n.init  = 1;
            end
        end else begin
            sent    = (m.pend < mx) ? m.pend : mx;
            after   = m.pend - sent + (rel_v ? rel_n : 0);
            n.phase = 2;
            n.rdy   = 1;
            n.upd   = (sent > 0) ? 1 : 0;
            n.cnt   = sent;
            if (after > ic) begin
                n.err  = 1;
                n.pend = m.pend - sent;
            end else begin
                n.pend = after;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mdl_step(ma, A_IC, A_MAX, rst, reinit, rel, int'(rel_cnt), ack);
        mb <= mdl_step(mb, B_IC, B_MAX, rst, reinit, rel, int'(rel_cnt), ack);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("a_init", 32'(a_init), ma.init);
        chk("a_update", 32'(a_upd), ma.upd);
        chk("a_update_cnt", 32'(a_cnt), ma.cnt);
        chk("a_ready", 32'(a_rdy), ma.rdy);
        chk("a_err", 32'(a_err), ma.err);
        chk("b_init", 32'(b_init), mb.init);
        chk("b_update", 32'(b_upd), mb.upd);
        chk("b_update_cnt", 32'(b_cnt), mb.cnt);
        chk("b_ready", 32'(b_rdy), mb.rdy);
        chk("b_err", 32'(b_err), mb.err);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (a_upd === 1'b1) sum_a += int'(a_cnt);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; reinit = 1'b0; rel = 1'b0; rel_cnt = 4'd0; ack = 1'b0;
        ticks(2);
        chk("reset_init", 32'(a_init), 32'd0);
        chk("reset_ready", 32'(a_rdy), 32'd0);

        // Bring-up: INIT rises one edge after reset drops, burst 255/255/2 after ACK
        rst = 1'b0;
        tick();
        chk("bringup_init_rise", 32'(a_init), 32'd1);
        ticks(3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("bringup_init_fall", 32'(a_init), 32'd0);
        chk("bringup_ready", 32'(a_rdy), 32'd1);
        sum_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            burst[i] = int'(a_cnt);
        end
        chk("burst0", burst[0], 32'd255);
        chk("burst1", burst[1], 32'd255);
        chk("burst2", burst[2], 32'd2);
        tick();
        chk("burst_done", 32'(a_upd), 32'd0);
        chk("bringup_total", sum_a, 32'd512);

        // Steady release of 3 per cycle comes back one cycle later
        sum_a = 0;
        rel = 1'b1; rel_cnt = 4'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i > 0) chk("steady_cnt", 32'(a_cnt), 32'd3);
        end
        rel = 1'b0; rel_cnt = 4'd0;
        tick();
        chk("steady_last", 32'(a_cnt), 32'd3);
        tick();
        chk("steady_total", sum_a, 32'd30);

        // Random releases while running
        for (int i = 0; i < 300; i++) begin
            rel = 1'($urandom_range(0, 1));
            rel_cnt = 4'($urandom_range(0, 15));
            tick();
        end
        rel = 1'b0; rel_cnt = 4'd0;
        ticks(3);

        // REINIT in the middle of the initial burst
        reinit = 1'b1; tick(); reinit = 1'b0;
        tick();
        ticks(2);
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        reinit = 1'b1; tick(); reinit = 1'b0;
        chk("reinit_update_low", 32'(a_upd), 32'd0);
        chk("reinit_ready_low", 32'(a_rdy), 32'd0);
        tick();
        chk("reinit_init_high", 32'(a_init), 32'd1);
        ticks(3);
        ack = 1'b1; tick(); ack = 1'b0;
        sum_a = 0;
        ticks(5);
        chk("reinit_readvertise", sum_a, 32'd512);

        // Long INIT hold with releases that must be ignored, then late ACK
        reinit = 1'b1; tick(); reinit = 1'b0;
        tick();
        hold_upd = 0;
        for (int i = 0; i < 100; i++) begin
            rel = 1'($urandom_range(0, 1));
            rel_cnt = 4'($urandom_range(0, 15));
            tick();
            hold_upd += int'(a_upd);
        end
        rel = 1'b0; rel_cnt = 4'd0;
        chk("hold_no_update", hold_upd, 32'd0);
        chk("hold_init", 32'(a_init), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        sum_a = 0;
        ticks(5);
        chk("late_ack_total", sum_a, 32'd512);

        // RESET while waiting for ACK
        reinit = 1'b1; tick(); reinit = 1'b0;
        ticks(3);
        rst = 1'b1; tick();
        chk("reset_in_init", 32'(a_init), 32'd0);
        tick(); rst = 1'b0;
        tick();
        chk("reset_init_back", 32'(a_init), 32'd1);

        // Over-release on the small instance; the default one just returns the extra
        ack = 1'b1; tick(); ack = 1'b0;
        sum_a = 0;
        rel = 1'b1; rel_cnt = 4'd15; tick(); rel = 1'b0; rel_cnt = 4'd0;
        chk("b_err_pulse", 32'(b_err), 32'd1);
        chk("a_no_err", 32'(a_err), 32'd0);
        tick();
        chk("b_err_clear", 32'(b_err), 32'd0);
        ticks(4);
        chk("a_total_with_release", sum_a, 32'd527);

        // REINIT beats INIT_ACK in the same cycle; RESET with REINIT
        reinit = 1'b1; tick(); reinit = 1'b0;
        ticks(2);
        reinit = 1'b1; ack = 1'b1; tick(); reinit = 1'b0; ack = 1'b0;
        chk("reinit_beats_ack", 32'(a_rdy), 32'd0);
        tick();
        rst = 1'b1; reinit = 1'b1; tick(); rst = 1'b0; reinit = 1'b0;
        chk("reset_with_reinit", 32'(a_init), 32'd0);

        // Random soak over all inputs
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            reinit  = ($urandom_range(0, 149) == 0);
            ack     = ($urandom_range(0, 3) == 0);
            rel     = 1'($urandom_range(0, 1));
            rel_cnt = 4'($urandom_range(0, 15));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
